// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Sequences a wide (4*NIBBLES-bit) addition through an external 4-bit
// registered carry-lookahead adder stage, one nibble per cycle. The stage's
// registered carry-out is fed back as the next nibble's carry-in, and the
// returned 5-bit results are assembled into the wide sum.
//
// Ports
//   clk      : clock, all state updates on posedge
//   rst      : asynchronous, active-high reset
//   start    : request, accepted when start=1 and ready=1
//   a, b     : operands (W bits), sampled on accept
//   cin      : carry-in of the wide add, sampled on accept
//   ready    : high only while idle
//   done     : one-cycle pulse, sum/cout valid
//   sum      : wide result, held until the next accept or reset
//   cout     : final carry-out, held with sum
//   cla_x    : A nibble presented to the adder stage (registered)
//   cla_y    : B nibble presented to the adder stage (registered)
//   cla_cin  : carry-in to the adder stage (combinational)
//   cla_r    : adder stage result {carry, sum[3:0]}, one cycle after inputs
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   ready,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [3:0]             cla_x,
    output logic [3:0]             cla_y,
    output logic                   cla_cin,
    input  logic [4:0]             cla_r
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  idx;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           cin_q;
    logic           accept;

    assign accept = (state == S_IDLE) && start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)          state_nxt = S_ISSUE;
            S_ISSUE: if (idx == LAST_IDX) state_nxt = S_DRAIN;
            S_DRAIN:                      state_nxt = S_DONE;
            S_DONE:                       state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs registered from the next state so they track state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            ready <= (state_nxt == S_IDLE);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Carry into the stage: latched cin for nibble 0, then the live registered
    // carry of the previous nibble; zero whenever nothing is being issued
    always_comb begin
        cla_cin = 1'b0;
        if (state == S_ISSUE) begin
            cla_cin = (idx == '0) ? cin_q : cla_r[4];
        end
    end

    // Operand latch, nibble issue and result assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            idx   <= '0;
            cla_x <= '0;
            cla_y <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        cin_q <= cin;
                        idx   <= '0;
                        cla_x <= a[3:0];
                        cla_y <= b[3:0];
                    end
                end
                S_ISSUE: begin
                    // Result of nibble idx-1 is on cla_r during this cycle
                    for (int n = 1; n < NIBBLES; n++) begin
                        if (idx == IW'(n)) begin
                            sum[4*(n-1) +: 4] <= cla_r[3:0];
                        end
                    end
                    if (idx != LAST_IDX) begin
                        idx   <= idx + IW'(1);
                        cla_x <= 4'(a_q >> (4 * (32'(idx) + 32'd1)));
                        cla_y <= 4'(b_q >> (4 * (32'(idx) + 32'd1)));
                    end
                end
                S_DRAIN: begin
                    // Top nibble's result and its carry-out arrive last
                    sum[W-1 -: 4] <= cla_r[3:0];
                    cout          <= cla_r[4];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 4 * N;
    localparam int unsigned N2 = 2;
    localparam int unsigned W2 = 4 * N2;

    typedef logic [W:0] wide_t;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           acc;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Main instance (NIBBLES=4)
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         ready, done, cout, cla_cin;
    logic [W-1:0] sum;
    logic [3:0]   cla_x, cla_y;
    logic [4:0]   cla_r;

    // Second instance (NIBBLES=2)
    logic          start2 = 1'b0;
    logic [W2-1:0] a2 = '0, b2 = '0;
    logic          cin2 = 1'b0;
    logic          ready2, done2, cout2, cla_cin2;
    logic [W2-1:0] sum2;
    logic [3:0]    cla_x2, cla_y2;
    logic [4:0]    cla_r2;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .done(done), .sum(sum), .cout(cout),
        .cla_x(cla_x), .cla_y(cla_y), .cla_cin(cla_cin), .cla_r(cla_r)
    );

    nibble_serial_add_ctrl #(.NIBBLES(N2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .ready(ready2), .done(done2), .sum(sum2), .cout(cout2),
        .cla_x(cla_x2), .cla_y(cla_y2), .cla_cin(cla_cin2), .cla_r(cla_r2)
    );

    // Registered 4-bit adder stages: no reset, enable tied high
    always @(posedge clk) cla_r  <= {1'b0, cla_x}  + {1'b0, cla_y}  + {4'd0, cla_cin};
    always @(posedge clk) cla_r2 <= {1'b0, cla_x2} + {1'b0, cla_y2} + {4'd0, cla_cin2};

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   prev_acc = -1;
    int   n_cont = 0;
    bit   cont_mode = 1'b0;
    op_t  sb[$];
    logic [W-1:0] last_sum;
    logic         last_cout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib(input logic [W-1:0] x, input int j);
        return 4'(x >> (4 * j));
    endfunction

    // Carry into bit 4j of a+b+cin, from plain arithmetic on the low bits
    function automatic logic carry_into(input op_t op, input int j);
        wide_t mask, s;
        mask = (wide_t'(1) << (4 * j)) - wide_t'(1);
        s = (wide_t'(op.a) & mask) + (wide_t'(op.b) & mask) + wide_t'(op.cin);
        return s[4*j];
    endfunction

    // Stimulus side: push expected operation on every accepted request
    always @(posedge clk) begin
        cyc++;
        if (!rst && start && ready) begin
            if (cont_mode) begin
                n_cont++;
                if (prev_acc >= 0) chk("accept_spacing", 32'(cyc - prev_acc), 32'(N + 3));
                prev_acc = cyc;
            end
            sb.push_back('{a: a, b: b, cin: cin, acc: cyc});
        end
    end

    // Monitor: per-cycle checks of the in-flight operation, result at done
    always @(negedge clk) begin
        int    k;
        op_t   op;
        wide_t s;
        if (!rst) begin
            if (sb.size() != 0) begin
                op = sb[0];
                k  = cyc - op.acc + 1;
                if (k >= 1 && k <= int'(N)) begin
                    chk("cla_x",   32'(cla_x),   32'(nib(op.a, k - 1)));
                    chk("cla_y",   32'(cla_y),   32'(nib(op.b, k - 1)));
                    chk("cla_cin", 32'(cla_cin), 32'(carry_into(op, k - 1)));
                end
                chk("ready_busy", 32'(ready), 32'd0);
                chk("done_timing", 32'(done), 32'(k == int'(N) + 2));
                if (k >= int'(N) + 2) begin
                    s = wide_t'(op.a) + wide_t'(op.b) + wide_t'(op.cin);
                    chk("sum",  32'(sum),  32'(s[W-1:0]));
                    chk("cout", 32'(cout), 32'(s[W]));
                    last_sum  = sum;
                    last_cout = cout;
                    void'(sb.pop_front());
                end
            end else begin
                chk("ready_idle", 32'(ready), 32'd1);
                chk("done_idle",  32'(done),  32'd0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = ci;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        #20;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_sum",   32'(sum),   32'd0);
        chk("rst_cout",  32'(cout),  32'd0);
        chk("rst_cla_x", 32'(cla_x), 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        // Full carry ripple
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_idle();
        chk("tp_ripple_sum",  32'(last_sum),  32'h0000);
        chk("tp_ripple_cout", 32'(last_cout), 32'd1);

        issue(16'h1234, 16'h4321, 1'b1);
        wait_idle();
        chk("tp_1234_sum",  32'(last_sum),  32'h5556);
        chk("tp_1234_cout", 32'(last_cout), 32'd0);

        // Back-to-back, stale carry must not leak
        issue(16'h8000, 16'h8000, 1'b0);
        issue(16'h0000, 16'h0000, 1'b0);
        wait_idle();
        chk("tp_b2b_sum",  32'(last_sum),  32'h0000);
        chk("tp_b2b_cout", 32'(last_cout), 32'd0);

        // Reset in C3 of an operation
        issue(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready",   32'(ready),   32'd1);
        chk("mid_rst_done",    32'(done),    32'd0);
        chk("mid_rst_sum",     32'(sum),     32'd0);
        chk("mid_rst_cout",    32'(cout),    32'd0);
        chk("mid_rst_cla_x",   32'(cla_x),   32'd0);
        chk("mid_rst_cla_y",   32'(cla_y),   32'd0);
        chk("mid_rst_cla_cin", 32'(cla_cin), 32'd0);
        sb.delete();
        @(posedge clk); #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(16'h0F0F, 16'hF0F1, 1'b0);
        wait_idle();
        chk("tp_post_rst_sum",  32'(last_sum),  32'h0000);
        chk("tp_post_rst_cout", 32'(last_cout), 32'd1);

        // start held high, operands changing every cycle
        cont_mode = 1'b1;
        prev_acc  = -1;
        start     = 1'b1;
        repeat (45) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        cont_mode = 1'b0;
        wait_idle();
        chk("cont_accepts", 32'(n_cont >= 6), 32'd1);

        // Randomized operations with junk start pulses in between
        repeat (30) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 8)) begin
                start = 1'($urandom);
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
        end
        wait_idle();

        // NIBBLES=2 instance
        @(negedge clk);
        chk("n2_ready", 32'(ready2), 32'd1);
        start2 = 1'b1; a2 = 8'hFF; b2 = 8'h01; cin2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("n2_latency", 32'(n), 32'd4);
        chk("n2_sum",     32'(sum2),  32'h01);
        chk("n2_cout",    32'(cout2), 32'd1);
        @(negedge clk);
        chk("n2_ready_back", 32'(ready2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
